// File: rtl/cordic_phase_nco.sv
// Phase NCO feeding the CORDIC rotator: a tick-gated phase accumulator with a
// single-entry FTW holding register, offset add, and a valid flag aligned to CORDIC latency.
module cordic_phase_nco #(
  parameter int unsigned PW  = 12,
  parameter int unsigned FW  = 24,
  parameter int unsigned DW  = 16,
  parameter int unsigned LAT = 13
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          enable,
  input  logic [DW-1:0] div,
  input  logic [PW-1:0] phase_offset,
  input  logic [FW-1:0] ftw_in,
  input  logic          ftw_valid,
  output logic          ftw_ready,
  output logic [PW-1:0] o_phase,
  output logic          o_phase_strobe,
  output logic          o_wrap,
  output logic          o_sample_valid
);

  logic [DW-1:0]  count_q, count_d;
  logic [FW-1:0]  acc_q, acc_d;
  logic [FW-1:0]  ftw_active_q, ftw_active_d;
  logic [FW-1:0]  ftw_pending_q, ftw_pending_d;
  logic           pending_q, pending_d;
  logic [PW-1:0]  phase_q, phase_d;
  logic           strobe_q, strobe_d;
  logic           wrap_q, wrap_d;
  logic [LAT-1:0] vld_q;
  logic           tick;
  logic           xfer;
  logic [FW:0]    sum;

  always_comb begin
    tick          = enable && (count_q == div);
    xfer          = ftw_valid && !pending_q;
    sum           = {1'b0, acc_q} + {1'b0, ftw_active_q};
    count_d       = count_q;
    acc_d         = acc_q;
    ftw_active_d  = ftw_active_q;
    ftw_pending_d = ftw_pending_q;
    pending_d     = pending_q;
    phase_d       = phase_q;
    strobe_d      = tick;
    wrap_d        = tick && sum[FW];

    // No reload when div drops below count: the counter runs through its wrap.
    if (enable) begin
      count_d = tick ? '0 : count_q + 1'b1;
    end

    // xfer needs !pending_q and the swap needs pending_q, so they never collide;
    // a transfer landing on a tick therefore waits for the following tick.
    if (xfer) begin
      ftw_pending_d = ftw_in;
      pending_d     = 1'b1;
    end else if (tick && pending_q) begin
      ftw_active_d = ftw_pending_q;
      pending_d    = 1'b0;
    end

    if (tick) begin
      acc_d   = sum[FW-1:0];
      phase_d = sum[FW-1 -: PW] + phase_offset;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      count_q       <= '0;
      acc_q         <= '0;
      ftw_active_q  <= '0;
      ftw_pending_q <= '0;
      pending_q     <= 1'b0;
      phase_q       <= '0;
      strobe_q      <= 1'b0;
      wrap_q        <= 1'b0;
    end else begin
      count_q       <= count_d;
      acc_q         <= acc_d;
      ftw_active_q  <= ftw_active_d;
      ftw_pending_q <= ftw_pending_d;
      pending_q     <= pending_d;
      phase_q       <= phase_d;
      strobe_q      <= strobe_d;
      wrap_q        <= wrap_d;
    end
  end

  // Shifts every clock regardless of enable so in-flight samples drain.
  always_ff @(posedge clk) begin
    if (reset) begin
      vld_q <= '0;
    end else begin
      vld_q[0] <= strobe_q;
      for (int unsigned i = 1; i < LAT; i++) begin
        vld_q[i] <= vld_q[i-1];
      end
    end
  end

  assign ftw_ready      = !pending_q;
  assign o_phase        = phase_q;
  assign o_phase_strobe = strobe_q;
  assign o_wrap         = wrap_q;
  assign o_sample_valid = vld_q[LAT-1];

endmodule
